alu_div_sequencer: RTL and testbench

ALU_DIV_SEQUENCER -- requirements
Module: alu_div_sequencer

---
 rtl/alu_div_sequencer_if.sv | 34 +++
 rtl/alu_div_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_div_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_div_sequencer_if.sv
// Bundle of the division request/result signals and the external ALU bus
// used by alu_div_sequencer.
//   start, dividend, divisor     : division request (requester -> sequencer)
//   busy, done, quotient,
//   remainder, div_by_zero       : status and result (sequencer -> requester)
//   ALUOperation, A, B           : opcode and operands (sequencer -> ALU)
//   ALUResult, Zero              : same-cycle ALU response (ALU -> sequencer)
// The master modport is the environment (requester plus ALU); the slave
// modport is the sequencer.
interface alu_div_sequencer_if;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUResult;
  logic        Zero;

  modport master (
    output start, dividend, divisor, ALUResult, Zero,
    input  busy, done, quotient, remainder, div_by_zero, ALUOperation, A, B
  );

  modport slave (
    input  start, dividend, divisor, ALUResult, Zero,
    output busy, done, quotient, remainder, div_by_zero, ALUOperation, A, B
  );
endinterface

// File: rtl/alu_div_sequencer.sv
// Restoring 16-bit unsigned divider that uses an external combinational ALU.
// It checks for a zero divisor with an OR, then runs 16 restoring steps with
// SUB, registering quotient/remainder/div_by_zero on entry to DONE.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : alu_div_sequencer_if.slave (request, result and ALU signals)
module alu_div_sequencer #(
  parameter logic [3:0] OP_OR   = 4'b0001,
  parameter logic [3:0] OP_SUB  = 4'b0100,
  parameter logic [3:0] OP_IDLE = 4'b0000
) (
  input logic                  clk,
  input logic                  reset,
  alu_div_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] dividend_reg;
  logic [15:0] divisor_reg;
  logic [15:0] r;
  logic [15:0] q_shift;
  logic [3:0]  cnt;
  logic [15:0] quotient_reg;
  logic [15:0] remainder_reg;
  logic        dbz_reg;

  logic [16:0] s;
  logic        q_bit;
  logic [15:0] r_next;
  logic [15:0] q_next;

  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;

  // Only the sign and the low half of the ALU result are meaningful here.
  logic        alu_hi_unused;
  assign alu_hi_unused = ^bus.ALUResult[30:16];

  // Restoring step: a non-negative difference means the divisor fit.
  always_comb begin
    s      = {r, dividend_reg[cnt]};
    q_bit  = ~bus.ALUResult[31];
    r_next = q_bit ? bus.ALUResult[15:0] : s[15:0];
    q_next = {q_shift[14:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_op     = OP_IDLE;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = CHECK;
      end
      CHECK: begin
        alu_op     = OP_OR;
        alu_a      = {16'h0, divisor_reg};
        state_next = bus.Zero ? DONE : ITER;
      end
      ITER: begin
        alu_op = OP_SUB;
        alu_a  = {15'h0, s};
        alu_b  = {16'h0, divisor_reg};
        if (cnt == 4'd0) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      r             <= '0;
      q_shift       <= '0;
      cnt           <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dividend_reg <= bus.dividend;
            divisor_reg  <= bus.divisor;
            r            <= '0;
            q_shift      <= '0;
            cnt          <= 4'd15;
          end
        end
        CHECK: begin
          if (bus.Zero) begin
            quotient_reg  <= 16'hFFFF;
            remainder_reg <= dividend_reg;
            dbz_reg       <= 1'b1;
          end
        end
        ITER: begin
          r       <= r_next;
          q_shift <= q_next;
          cnt     <= cnt - 4'd1;
          // Results are taken from the final step's values directly so they
          // are already valid in the DONE cycle.
          if (cnt == 4'd0) begin
            quotient_reg  <= q_next;
            remainder_reg <= r_next;
            dbz_reg       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.quotient     = quotient_reg;
  assign bus.remainder    = remainder_reg;
  assign bus.div_by_zero  = dbz_reg;
  assign bus.ALUOperation = alu_op;
  assign bus.A            = alu_a;
  assign bus.B            = alu_b;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Self-checking bench for alu_div_sequencer with a behavioural ALU model.
module tb_alu_div_sequencer;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_IDLE = 4'b0000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  alu_div_sequencer_if bus ();

  alu_div_sequencer #(
    .OP_OR   (OP_OR),
    .OP_SUB  (OP_SUB),
    .OP_IDLE (OP_IDLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    case (bus.ALUOperation)
      OP_AND:  bus.ALUResult = bus.A & bus.B;
      OP_OR:   bus.ALUResult = bus.A | bus.B;
      OP_NOR:  bus.ALUResult = ~(bus.A | bus.B);
      OP_ADD:  bus.ALUResult = bus.A + bus.B;
      OP_SUB:  bus.ALUResult = bus.A - bus.B;
      default: bus.ALUResult = 32'h0;
    endcase
    bus.Zero = (bus.ALUResult == 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("alu_op_legal",
        {31'h0, (bus.ALUOperation == OP_IDLE) || (bus.ALUOperation == OP_OR) ||
                (bus.ALUOperation == OP_SUB)}, 32'h1);
  end

  // Called at the negedge of cycle 1; returns at the negedge of the done cycle.
  task automatic wait_done(input int glitch_cyc, input logic [15:0] gdd, input logic [15:0] gdv,
                           output int lat, output int or_cnt, output int or_first);
    lat = 1; or_cnt = 0; or_first = 0;
    while (!bus.done && lat < 40) begin
      chk("busy_during_op", {31'h0, bus.busy}, 32'h1);
      if (bus.ALUOperation == OP_OR) begin
        or_cnt++;
        if (or_first == 0) or_first = lat;
      end
      if (lat == glitch_cyc) begin
        bus.start = 1'b1; bus.dividend = gdd; bus.divisor = gdv;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (!bus.done) chk("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic run_div(input string name, input logic [15:0] dd, input logic [15:0] dv,
                         input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                         input int elat);
    int lat, or_cnt, or_first;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = dd; bus.divisor = dv;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(0, 16'h0, 16'h0, lat, or_cnt, or_first);
    chk({name, "_latency"}, lat, elat);
    chk({name, "_quotient"}, {16'h0, bus.quotient}, {16'h0, eq});
    chk({name, "_remainder"}, {16'h0, bus.remainder}, {16'h0, er});
    chk({name, "_dbz"}, {31'h0, bus.div_by_zero}, {31'h0, edbz});
    chk({name, "_or_count"}, or_cnt, 1);
    chk({name, "_or_cycle"}, or_first, 1);
    @(negedge clk);
    chk({name, "_done_pulse"}, {31'h0, bus.done}, 32'h0);
    chk({name, "_idle"}, {31'h0, bus.busy}, 32'h0);
    chk({name, "_q_hold"}, {16'h0, bus.quotient}, {16'h0, eq});
    chk({name, "_r_hold"}, {16'h0, bus.remainder}, {16'h0, er});
    chk({name, "_dbz_hold"}, {31'h0, bus.div_by_zero}, {31'h0, edbz});
    chk({name, "_op_idle"}, {28'h0, bus.ALUOperation}, {28'h0, OP_IDLE});
  endtask

  typedef struct {
    string       name;
    logic [15:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, or_cnt, or_first, n_done;
    n_checks = 0; n_fail = 0;

    vecs[0] = '{"d100_7",   16'd100,   16'd7,     16'd14,    16'd2,   1'b0, 18};
    vecs[1] = '{"ffff_1",   16'hFFFF,  16'd1,     16'hFFFF,  16'd0,   1'b0, 18};
    vecs[2] = '{"ffff_ffff",16'hFFFF,  16'hFFFF,  16'd1,     16'd0,   1'b0, 18};
    vecs[3] = '{"d3_10",    16'd3,     16'd10,    16'd0,     16'd3,   1'b0, 18};
    vecs[4] = '{"d0_5",     16'd0,     16'd5,     16'd0,     16'd0,   1'b0, 18};
    vecs[5] = '{"d5_0",     16'd5,     16'd0,     16'hFFFF,  16'd5,   1'b1, 2};
    vecs[6] = '{"d1000_33", 16'd1000,  16'd33,    16'd30,    16'd10,  1'b0, 18};
    vecs[7] = '{"ffff_256", 16'hFFFF,  16'd256,   16'd255,   16'd255, 1'b0, 18};

    reset = 1'b0; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_quotient", {16'h0, bus.quotient}, 32'h0);
    chk("rst_remainder", {16'h0, bus.remainder}, 32'h0);
    chk("rst_dbz", {31'h0, bus.div_by_zero}, 32'h0);
    chk("rst_op", {28'h0, bus.ALUOperation}, {28'h0, OP_IDLE});
    chk("rst_a", bus.A, 32'h0);
    chk("rst_b", bus.B, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++)
      run_div(vecs[i].name, vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);

    // Start while busy is ignored; start in DONE ignored, then accepted in IDLE.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6, 16'd50, 16'd3, lat, or_cnt, or_first);
    chk("glitch_latency", lat, 18);
    chk("glitch_quotient", {16'h0, bus.quotient}, 32'd14);
    chk("glitch_remainder", {16'h0, bus.remainder}, 32'd2);
    bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 16'd3;
    @(negedge clk);
    chk("start_in_done_ignored", {31'h0, bus.busy}, 32'h0);
    chk("start_in_done_no_done", {31'h0, bus.done}, 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_after_done_accepted", {31'h0, bus.busy}, 32'h1);
    wait_done(0, 16'h0, 16'h0, lat, or_cnt, or_first);
    chk("d50_3_latency", lat, 18);
    chk("d50_3_quotient", {16'h0, bus.quotient}, 32'd16);
    chk("d50_3_remainder", {16'h0, bus.remainder}, 32'd2);
    @(negedge clk);

    // Reset in cycle 9 aborts the division.
    bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy_before", {31'h0, bus.busy}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    chk("abort_quotient", {16'h0, bus.quotient}, 32'h0);
    chk("abort_remainder", {16'h0, bus.remainder}, 32'h0);
    chk("abort_dbz", {31'h0, bus.div_by_zero}, 32'h0);
    chk("abort_op", {28'h0, bus.ALUOperation}, {28'h0, OP_IDLE});
    chk("abort_a", bus.A, 32'h0);
    chk("abort_b", bus.B, 32'h0);
    reset = 1'b1;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    run_div("d9_4", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
